// File: rtl/ddr_output_serializer.sv
// DDR/SDR output serializer for the RGMII transmit pads: buffers 2*OUTPUT_WIDTH-bit
// words in a small FIFO and launches them one half per clock edge or one half per cycle.
module ddr_output_serializer #(
    parameter int                      OUTPUT_WIDTH = 4,
    parameter int                      FIFO_DEPTH   = 8,
    parameter logic [OUTPUT_WIDTH-1:0] IDLE_VALUE   = '0
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [2*OUTPUT_WIDTH-1:0]       input_data,
    input  logic                            input_valid,
    input  logic                            input_last,
    output logic                            input_ready,
    input  logic                            sdr_mode,
    input  logic                            high_half_first,
    input  logic                            clear_underflow,
    output logic [OUTPUT_WIDTH-1:0]         ddr_output,
    output logic                            output_active,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            debug_sdr_phase
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = 2 * OUTPUT_WIDTH + 1;

    localparam logic [0:0] PHASE0 = 1'b0;
    localparam logic [0:0] PHASE1 = 1'b1;

    // Handshake: a word transfers at a rising edge where input_valid && input_ready;
    // input_ready depends only on registered occupancy, never on input_valid.

    logic [WW-1:0]           mem_q [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [0:0]              phase_q, phase_d;
    logic [OUTPUT_WIDTH-1:0] pos_q, pos_d;
    logic [OUTPUT_WIDTH-1:0] second_q, second_d;
    logic [OUTPUT_WIDTH-1:0] held_q, held_d;
    logic [OUTPUT_WIDTH-1:0] neg_q, neg_d;
    logic                    active_q, active_d;
    logic                    in_frame_q, in_frame_d;
    logic                    underflow_q, underflow_d;

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    uf_set;
    logic [WW-1:0]           rd_word;
    logic [OUTPUT_WIDTH-1:0] lo_half;
    logic [OUTPUT_WIDTH-1:0] hi_half;
    logic [OUTPUT_WIDTH-1:0] first_half;
    logic [OUTPUT_WIDTH-1:0] last_half;

    assign fifo_level  = wr_ptr_q - rd_ptr_q;
    assign full        = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign input_ready = !full;
    assign push        = input_valid && !full;

    assign rd_word    = mem_q[rd_ptr_q[AW-1:0]];
    assign lo_half    = rd_word[OUTPUT_WIDTH-1:0];
    assign hi_half    = rd_word[2*OUTPUT_WIDTH-1:OUTPUT_WIDTH];
    assign first_half = high_half_first ? hi_half : lo_half;
    assign last_half  = high_half_first ? lo_half : hi_half;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        second_d   = second_q;
        held_d     = held_q;
        active_d   = 1'b0;
        in_frame_d = in_frame_q;
        uf_set     = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // Mode inputs are only looked at when a word leaves the FIFO, so a word in
        // flight always finishes in the mode it started with.
        if (phase_q == PHASE1) begin
            pos_d    = held_q;
            second_d = held_q;
            active_d = 1'b1;
            phase_d  = PHASE0;
        end else if (!empty) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            active_d   = 1'b1;
            in_frame_d = !rd_word[WW-1];
            pos_d      = first_half;
            if (sdr_mode) begin
                second_d = first_half;
                held_d   = last_half;
                phase_d  = PHASE1;
            end else begin
                second_d = last_half;
            end
        end else begin
            pos_d    = IDLE_VALUE;
            second_d = IDLE_VALUE;
            uf_set   = in_frame_q;
        end

        if (uf_set) begin
            underflow_d = 1'b1;
        end else if (clear_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    always_comb begin
        neg_d = second_q;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {input_last, input_data};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            phase_q     <= PHASE0;
            pos_q       <= '0;
            second_q    <= '0;
            held_q      <= '0;
            active_q    <= 1'b0;
            in_frame_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            second_q    <= second_d;
            held_q      <= held_d;
            active_q    <= active_d;
            in_frame_q  <= in_frame_d;
            underflow_q <= underflow_d;
        end
    end

    // Second half moves to the pins on the falling edge; in SDR it equals the first.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= '0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign ddr_output      = clock ? pos_q : neg_q;
    assign output_active   = active_q;
    assign underflow       = underflow_q;
    assign debug_sdr_phase = phase_q[0];

endmodule
